// File: rtl/ll_node_alloc.sv
// Free-node allocator: free bitmap, lowest-free isolation, registered alloc candidate.
// Latency: candidate valid two edges after reset release and one edge after each handshake.
// Backpressure: a held candidate waits for alloc_req_i; requests without alloc_rdy_o are ignored.
module ll_node_alloc #(
   parameter int NUM_NODES = 16,
   localparam int IDX_W = $clog2(NUM_NODES),
   localparam int CNT_W = $clog2(NUM_NODES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc_req_i,
   output logic             alloc_rdy_o,
   output logic [IDX_W-1:0] alloc_idx_o,
   input  logic             free_vld_i,
   input  logic [IDX_W-1:0] free_idx_i,
   output logic [CNT_W-1:0] free_cnt_o,
   output logic             empty_o,
   output logic             err_dbl_free_o
);

   // INIT: first edge after reset; REFILL: pick a candidate from the map;
   // HOLD: candidate presented; DRY: no candidate because the map is empty.
   typedef enum logic [1:0] {
      S_INIT   = 2'd0,
      S_REFILL = 2'd1,
      S_HOLD   = 2'd2,
      S_DRY    = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [NUM_NODES-1:0] free_map_q, free_map_d;
   logic [IDX_W-1:0]     cand_q, cand_d;
   logic                 rdy_q, rdy_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 err_q, err_d;

   logic [NUM_NODES-1:0] iso;
   logic                 iso_found;
   logic [IDX_W-1:0]     pos;
   logic                 map_nonempty;
   logic                 hs;
   logic [IDX_W-1:0]     cand_bit;
   logic [IDX_W-1:0]     free_bit;
   logic                 free_ok;
   logic                 dbl_free;

   // Node p lives at bit NUM_NODES-1-p; with NUM_NODES a power of two that is ~p.
   assign cand_bit = ~cand_q;
   assign free_bit = ~free_idx_i;

   assign map_nonempty = |free_map_q;
   assign hs           = (state_q == S_HOLD) && alloc_req_i;
   assign free_ok      = free_vld_i && !free_map_q[free_bit];
   assign dbl_free     = free_vld_i &&  free_map_q[free_bit];

   // Keep only the highest set bit of the map, i.e. the lowest free node index.
   always_comb begin
      iso       = '0;
      iso_found = 1'b0;
      for (int b = NUM_NODES - 1; b >= 0; b--) begin
         if (free_map_q[b] && !iso_found) begin
            iso[b]    = 1'b1;
            iso_found = 1'b1;
         end
      end
   end

   // Encode the one-hot vector back to a node index (MSB encodes index 0).
   always_comb begin
      pos = '0;
      for (int b = 0; b < NUM_NODES; b++) begin
         if (iso[b]) begin
            pos = pos | IDX_W'(NUM_NODES - 1 - b);
         end
      end
   end

   // Next-state and datapath decisions, all taken from pre-edge register values.
   always_comb begin
      state_d    = state_q;
      free_map_d = free_map_q;
      cand_d     = cand_q;
      rdy_d      = rdy_q;
      cnt_d      = cnt_q;
      err_d      = dbl_free;

      unique case (state_q)
         S_INIT: begin
            state_d = S_REFILL;
         end
         S_REFILL, S_DRY: begin
            if (map_nonempty) begin
               state_d = S_HOLD;
               cand_d  = pos;
               rdy_d   = 1'b1;
            end else begin
               state_d = S_DRY;
            end
         end
         S_HOLD: begin
            if (alloc_req_i) begin
               // The candidate stays marked free until it is actually taken.
               state_d              = S_REFILL;
               rdy_d                = 1'b0;
               free_map_d[cand_bit] = 1'b0;
            end
         end
         default: begin
            state_d = S_INIT;
            rdy_d   = 1'b0;
         end
      endcase

      // A valid free can never hit the candidate (it is free), so it never
      // collides with the bit cleared by a same-edge handshake.
      if (free_ok) begin
         free_map_d[free_bit] = 1'b1;
      end

      unique case ({free_ok, hs})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // State register; reset discards every allocation and any held candidate.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Bitmap, candidate, counter and error flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         free_map_q <= '1;
         cand_q     <= '0;
         rdy_q      <= 1'b0;
         cnt_q      <= CNT_W'(NUM_NODES);
         err_q      <= 1'b0;
      end else begin
         free_map_q <= free_map_d;
         cand_q     <= cand_d;
         rdy_q      <= rdy_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

   assign alloc_rdy_o    = rdy_q;
   assign alloc_idx_o    = cand_q;
   assign free_cnt_o     = cnt_q;
   assign empty_o        = (cnt_q == '0);
   assign err_dbl_free_o = err_q;

   // The counter is a cached popcount of the map and can never exceed the slot count.
   a_cnt_matches_map: assert property (@(posedge clk) disable iff (rst)
      (cnt_q == CNT_W'($countones(free_map_q))) && (cnt_q <= CNT_W'(NUM_NODES)));

   // A presented candidate is always still marked free.
   a_cand_is_free: assert property (@(posedge clk) disable iff (rst)
      (state_q != S_HOLD) || free_map_q[cand_bit]);

   // The ready flag is exactly the HOLD state.
   a_rdy_is_hold: assert property (@(posedge clk) disable iff (rst)
      rdy_q == (state_q == S_HOLD));

endmodule
